// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction memory read port, redirect input and the
// instruction stream handed to the datapath.
// The master side is the fetch unit; the slave side is memory plus datapath.
interface inst_fetch_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    // Instruction memory read port
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    // Control-flow change from the datapath
    logic          redirect;
    logic [31:0]   redirect_pc;

    // Instruction stream toward datapath and controlpath
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [CW-1:0] count;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output op,
        output funct,
        output count
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  op,
        input  funct,
        input  count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one word read at a time, buffers returned
// words with their addresses in a small FIFO, and restarts on redirect.
// Space in the FIFO is reserved when a request is issued, so a returning
// word always has a slot to land in.
module inst_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // FETCH_IDLE: nothing outstanding.
    // FETCH_WAIT: one request outstanding, its data will be kept.
    // FETCH_WAIT_KILL: request outstanding but a redirect overtook it, data dropped.
    typedef enum logic [1:0] {
        FETCH_IDLE      = 2'd0,
        FETCH_WAIT      = 2'd1,
        FETCH_WAIT_KILL = 2'd2
    } fetchState_t;

    fetchState_t   state_q;
    fetchState_t   state_d;

    logic [31:0]   fetchPc_q;
    logic [31:0]   fetchPc_d;
    logic [31:0]   memAddr_q;
    logic [31:0]   memAddr_d;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [AW-1:0] head_q;
    logic [AW-1:0] head_d;
    logic [AW-1:0] tail_q;
    logic [AW-1:0] tail_d;

    logic [31:0]   pcMem   [DEPTH];
    logic [31:0]   instMem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          flush;
    logic          headValid;
    logic [31:0]   headInst;
    logic [31:0]   headPc;
    logic [31:0]   redirectTarget;

    assign flush          = bus.redirect;
    assign redirectTarget = {bus.redirect_pc[31:2], 2'b00};
    assign headValid      = (count_q != '0);
    assign pop            = headValid && bus.inst_ready && !flush;

    // Request control: decides when to issue, and whether a returning word is kept.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (!flush && (count_q < CW'(DEPTH))) begin
                    issue   = 1'b1;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (bus.mem_ack) begin
                    push    = !flush;
                    state_d = FETCH_IDLE;
                end else if (flush) begin
                    state_d = FETCH_WAIT_KILL;
                end
            end
            FETCH_WAIT_KILL: begin
                if (bus.mem_ack) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // Request control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC moves to the redirect target, or past each word that is kept.
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (flush) begin
            fetchPc_d = redirectTarget;
        end else if (push) begin
            fetchPc_d = memAddr_q + 32'd4;
        end
    end

    // Read address is captured at issue and held until the word returns.
    always_comb begin
        memAddr_d = memAddr_q;
        if (issue) begin
            memAddr_d = fetchPc_q;
        end
    end

    // Fetch PC and read address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc_q <= RESET_PC;
            memAddr_q <= 32'h0000_0000;
        end else begin
            fetchPc_q <= fetchPc_d;
            memAddr_q <= memAddr_d;
        end
    end

    // FIFO bookkeeping: a redirect empties the buffer and overrides push/pop.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // FIFO storage; contents only matter where occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[tail_q]   <= memAddr_q;
            instMem[tail_q] <= bus.mem_rdata;
        end
    end

    // Head of the buffer, forced to zero while empty.
    always_comb begin
        headInst = 32'h0000_0000;
        headPc   = 32'h0000_0000;
        if (headValid) begin
            headInst = instMem[head_q];
            headPc   = pcMem[head_q];
        end
    end

    assign bus.mem_req    = (state_q != FETCH_IDLE);
    assign bus.mem_addr   = memAddr_q;
    assign bus.inst_valid = headValid;
    assign bus.inst       = headInst;
    assign bus.inst_pc    = headPc;
    assign bus.op         = headInst[31:26];
    assign bus.funct      = headInst[5:0];
    assign bus.count      = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch buffer.
module tb_inst_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    // Reference model: buffer as a pair of queues plus request bookkeeping.
    logic [31:0] mPc[$];
    logic [31:0] mInst[$];
    logic [31:0] mFpc;
    logic [31:0] mAddr;
    bit          mOut;
    bit          mKill;

    inst_fetch_if #(.DEPTH(DEPTH)) bus ();

    inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc.delete();
        mInst.delete();
        mFpc  = RESET_PC;
        mAddr = 32'h0;
        mOut  = 1'b0;
        mKill = 1'b0;
    endtask

    task automatic checkOutput();
        logic [31:0] eInst;
        logic [31:0] ePc;
        eInst = (mPc.size() != 0) ? mInst[0] : 32'h0;
        ePc   = (mPc.size() != 0) ? mPc[0]   : 32'h0;
        checkOne("mem_req",    32'(bus.mem_req),    32'(mOut));
        if (mOut) checkOne("mem_addr", bus.mem_addr, mAddr);
        checkOne("inst_valid", 32'(bus.inst_valid), 32'(mPc.size() != 0));
        checkOne("inst",       bus.inst,            eInst);
        checkOne("inst_pc",    bus.inst_pc,         ePc);
        checkOne("op",         32'(bus.op),         32'(eInst[31:26]));
        checkOne("funct",      32'(bus.funct),      32'(eInst[5:0]));
        checkOne("count",      32'(bus.count),      32'(mPc.size()));
    endtask

    task automatic resetCheck(input string tag);
        checkOne({tag, "_mem_req"},    32'(bus.mem_req),    32'h0);
        checkOne({tag, "_mem_addr"},   bus.mem_addr,        32'h0);
        checkOne({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'h0);
        checkOne({tag, "_inst"},       bus.inst,            32'h0);
        checkOne({tag, "_inst_pc"},    bus.inst_pc,         32'h0);
        checkOne({tag, "_op"},         32'(bus.op),         32'h0);
        checkOne({tag, "_funct"},      32'(bus.funct),      32'h0);
        checkOne({tag, "_count"},      32'(bus.count),      32'h0);
    endtask

    // One clock cycle: drive inputs, advance the model by the fetch rules, check after the edge.
    task automatic applyStimulus(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
        logic [31:0] rdata;
        logic [31:0] issueAddr;
        bit          ackEff;
        bit          doIssue;
        rdata           = $urandom;
        bus.mem_ack     = ack;
        bus.mem_rdata   = rdata;
        bus.inst_ready  = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        issueAddr = mFpc;
        ackEff    = ack && mOut;
        doIssue   = !mOut && (mPc.size() < DEPTH) && !redir;
        if (redir) begin
            mPc.delete();
            mInst.delete();
            mFpc  = {rpc[31:2], 2'b00};
            mKill = mOut && !ack;
        end else begin
            if (mPc.size() != 0 && ready) begin
                void'(mPc.pop_front());
                void'(mInst.pop_front());
            end
            if (ackEff) begin
                if (mKill) begin
                    mKill = 1'b0;
                end else begin
                    mPc.push_back(mAddr);
                    mInst.push_back(rdata);
                    mFpc = mAddr + 32'd4;
                end
            end
        end
        if (ackEff) begin
            mOut = 1'b0;
        end else if (doIssue) begin
            mOut  = 1'b1;
            mAddr = issueAddr;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset in mid-cycle; acks during reset must be ignored.
    task automatic doReset(input string tag);
        rst = 1'b0;
        #1;
        resetCheck(tag);
        bus.mem_ack    = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetCheck({tag, "_held"});
        bus.mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        modelReset();
    endtask

    initial begin
        rst             = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        resetCheck("por");
        @(negedge clk);
        rst = 1'b1;

        // Streaming with ack one cycle after each request and datapath always ready.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOne("first_addr", bus.mem_addr, RESET_PC);
        repeat (12) applyStimulus(mOut, 1'b1, 1'b0, 32'h0);

        // Datapath stalled: buffer fills to DEPTH and requests stop.
        doReset("rst_a");
        repeat (10) applyStimulus(mOut, 1'b0, 1'b0, 32'h0);
        checkOne("full_count", 32'(bus.count), 32'(DEPTH));
        checkOne("full_req", 32'(bus.mem_req), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOne("refill_req", 32'(bus.mem_req), 32'h1);
        checkOne("refill_addr", bus.mem_addr, 32'h0000_0010);

        // Redirect while the request to 8 is pending.
        doReset("rst_b");
        repeat (4) applyStimulus(mOut, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOne("pend_addr", bus.mem_addr, 32'h0000_0008);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOne("killed_valid", 32'(bus.inst_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOne("redir_addr", bus.mem_addr, 32'h0000_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOne("redir_inst_pc", bus.inst_pc, 32'h0000_0100);

        // Redirect coinciding with ack and pop while two entries are buffered.
        doReset("rst_c");
        repeat (5) applyStimulus(mOut, 1'b0, 1'b0, 32'h0);
        checkOne("two_count", 32'(bus.count), 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        checkOne("flush_count", 32'(bus.count), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOne("flush_addr", bus.mem_addr, 32'h0000_0200);

        // Address wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOne("wrap_top_addr", bus.mem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOne("wrap_zero_addr", bus.mem_addr, 32'h0000_0000);

        // Reset while a request is outstanding and three entries are buffered.
        doReset("rst_d");
        repeat (7) applyStimulus(mOut, 1'b0, 1'b0, 32'h0);
        checkOne("pre_rst_count", 32'(bus.count), 32'h3);
        checkOne("pre_rst_req", 32'(bus.mem_req), 32'h1);
        doReset("rst_mid");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOne("post_rst_addr", bus.mem_addr, RESET_PC);

        // Random traffic, including stray acks and redirects near the wrap point.
        for (int i = 0; i < 400; i++) begin
            bit          a;
            bit          r;
            bit          d;
            logic [31:0] t;
            a = mOut ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            r = bit'($urandom_range(0, 1));
            d = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(a, r, d, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
